logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, pipelined successor of the 4-op bitwise logic unit. Widens the operation set to
//   8 bitwise ops and computes Zero/Parity result flags. Adds valid/ready handshakes on input and
//   output, a configurable pipeline depth and an output-transaction counter.
//   Sits between operand fetch and the writeback mux of the lab ALU datapath.
// PARAMETERS
//   WIDTH   32  operand/result width in bits (>=1)
//   STAGES  2   pipeline depth = latency in cycles (legal 1..4; other values are illegal, flag at elaboration)
//   CNT_W   16  width of the completed-result counter
// PORTS
//   clk        in   1        rising-edge clock
//   reset_n    in   1        synchronous active-low reset
//   in_valid   in   1        op/a/b valid this cycle
//   in_ready   out  1        unit accepts input this cycle
//   op         in   3        operation select (see BEHAVIOUR)
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B
//   out_valid  out  1        y/zero/parity valid
//   out_ready  in   1        downstream accepts result
//   y          out  WIDTH    result
//   zero       out  1        y == 0
//   parity     out  1        XOR-reduction of y
//   done_cnt   out  CNT_W    number of completed output handshakes (wraps)
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous and active-low (reset_n sampled on rising clk edge).
//   - Reset (reset_n=0 at posedge): all stage valids=0, all stage data/flags=0, done_cnt=0.
//     Outputs after reset: out_valid=0, y=0, zero=0, parity=0, done_cnt=0.
//     in_ready=1 during and after reset. Inputs are ignored while reset_n=0.
//   - Reset mid-operation discards all in-flight results; no out_valid for them, ever.
//   - op: 000 AND; 001 OR; 010 XOR; 011 NOR; 100 NAND; 101 XNOR; 110 A&~B; 111 pass A.
//     Codes 000-011 match the legacy 2-bit encoding with op[2]=0.
//   - Accept: input handshake when in_valid && in_ready. Result is computed combinationally.
//     The result and its flags are registered into stage 1 and shifted one stage per cycle.
//     Stage STAGES drives y/zero/parity/out_valid directly from registers (no comb path to outputs).
//   - Latency: with no stall, a transaction accepted at edge N presents out_valid=1 after edge
//     N+STAGES-1. That is, it is visible in the cycle following edge N+STAGES-1.
//   - Throughput: 1 transaction/cycle while out_ready=1.
//   - Stall: stall = out_valid && !out_ready. While stalled, every stage holds (valid and data)
//     and in_ready=0. in_ready = !stall, combinational.
//   - Bubbles: stages with valid=0 advance normally. Valid=0 stage data is don't-care, but must
//     not cause out_valid=1.
//   - Hold rule: while out_valid=1 && out_ready=0, y/zero/parity must stay stable.
//   - Output handshake: out_valid && out_ready. On each handshake done_cnt += 1, modulo 2^CNT_W.
//     2^CNT_W-1 wraps to 0. There is no saturation and no flag.
//   - Simultaneous events: an input accept and an output handshake in the same cycle are both
//     honoured; nothing is lost or duplicated.
//   - Flags: zero = (y == {WIDTH{1'b0}}); parity = ^y; both computed before stage 1.
//   - in_valid with stall: input not accepted. Source must hold op/a/b. The unit does not sample them.
// TESTING
//   T1 reset: reset_n=0 for 2 cycles, in_valid=1 -> out_valid=0, done_cnt=0, y=0, in_ready=1.
//   T2 ops (WIDTH=32, STAGES=2), a=0xF0F0_00FF, b=0xFF00_0F0F:
//      000 -> 0xF000_000F; 001 -> 0xFFF0_0FFF; 010 -> 0x0FF0_0FF0; 011 -> 0x000F_F000;
//      100 -> 0x0FFF_FFF0; 101 -> 0xF00F_F00F; 110 -> 0x00F0_00F0; 111 -> 0xF0F0_00FF.
//      Each result appears exactly 2 cycles after accept.
//   T3 flags: op=010, a=b=0x1234_5678 -> y=0, zero=1, parity=0;
//      op=111, a=0x0000_0007 -> zero=0, parity=1.
//   T4 backpressure: stream 6 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream ->
//      in_ready=0 while stalled, y stable, all 6 results in order, done_cnt=6.
//   T5 wrap: CNT_W=4, 17 output handshakes -> done_cnt=1; no transaction lost.
//   T6 reset mid-flight: STAGES=3, accept 2 ops, assert reset_n=0 one cycle later ->
//      no out_valid for either op, done_cnt=0. A new op after reset has latency 3.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 8-op bitwise logic unit with zero/parity flags,
// valid/ready handshakes, STAGES-deep pipeline and a result counter.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] done_cnt
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_unit_pipe: STAGES must be in 1..4");
    end

    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_par;
    logic             stall;
    logic             hs_out;

    logic [STAGES-1:0] sv;
    logic [STAGES-1:0] sz;
    logic [STAGES-1:0] sp;
    logic [WIDTH-1:0]  sy [STAGES];

    // Bitwise operation select; codes 0-3 keep the legacy encoding.
    always_comb begin
        res = '0;
        unique case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = ~(a | b);
            3'b100:  res = ~(a & b);
            3'b101:  res = ~(a ^ b);
            3'b110:  res = a & ~b;
            default: res = a;
        endcase
    end

    // Flags are formed before stage 1 so the output side stays pure register.
    always_comb begin
        res_zero = (res == '0);
        res_par  = ^res;
    end

    // The whole pipe freezes only when the last stage holds an unaccepted result.
    always_comb begin
        stall    = sv[STAGES-1] && !out_ready;
        in_ready = !stall || !reset_n;
        hs_out   = sv[STAGES-1] && out_ready;
    end

    // Pipeline registers: load stage 1 with the new result (or a bubble), shift the rest.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sv <= '0;
            sz <= '0;
            sp <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sy[i] <= '0;
            end
        end else if (!stall) begin
            sv[0] <= in_valid;
            sy[0] <= res;
            sz[0] <= res_zero;
            sp[0] <= res_par;
            for (int i = 1; i < STAGES; i++) begin
                sv[i] <= sv[i-1];
                sy[i] <= sy[i-1];
                sz[i] <= sz[i-1];
                sp[i] <= sp[i-1];
            end
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_cnt <= '0;
        end else if (hs_out) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    assign out_valid = sv[STAGES-1];
    assign y         = sy[STAGES-1];
    assign zero      = sz[STAGES-1];
    assign parity    = sp[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed checks of logic_unit_pipe, one default
// instance (32/2/16) and one with STAGES=3, CNT_W=4.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        zero, parity;
    logic [2:0]  op;
    logic [31:0] a, b, y;
    logic [15:0] done_cnt;

    // STAGES=3, CNT_W=4 instance
    logic        rst2, iv2, ir2, ov2, or2, z2, p2;
    logic [2:0]  op2;
    logic [31:0] a2, b2, y2;
    logic [3:0]  dc2;

    int nchk = 0;
    int nerr = 0;

    logic_unit_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .done_cnt(done_cnt)
    );

    logic_unit_pipe #(.WIDTH(32), .STAGES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset_n(rst2),
        .in_valid(iv2), .in_ready(ir2),
        .op(op2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2),
        .y(y2), .zero(z2), .parity(p2), .done_cnt(dc2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one isolated op on the default instance, exact latency check
    task automatic run1(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] w, input logic [31:0] ey,
                        input logic ez, input logic ep);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = w;
        out_ready = 1'b1;
        #1;
        chk($sformatf("rdy_op%0d", o), in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk($sformatf("early_op%0d", o), out_valid, 0);
        tick();
        chk($sformatf("vld_op%0d", o), out_valid, 1);
        chk($sformatf("y_op%0d", o), y, ey);
        chk($sformatf("z_op%0d", o), zero, ez);
        chk($sformatf("p_op%0d", o), parity, ep);
    endtask

    localparam logic [31:0] TA = 32'hF0F0_00FF;
    localparam logic [31:0] TB = 32'hFF00_0F0F;

    logic [31:0] exp8 [8] = '{
        32'hF000_000F, 32'hFFF0_0FFF, 32'h0FF0_0FF0, 32'h000F_F000,
        32'h0FFF_FFF0, 32'hF00F_F00F, 32'h00F0_00F0, 32'hF0F0_00FF
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          sent;
        int          got;
        logic [31:0] held;
        logic        hold_v;

        // T1: reset with in_valid high on both instances
        rst_n = 1'b0; in_valid = 1'b1; op = 3'b001;
        a = 32'hFFFF_FFFF; b = 32'h1; out_ready = 1'b1;
        rst2 = 1'b0; iv2 = 1'b0; op2 = 3'b111;
        a2 = 32'h0; b2 = 32'h0; or2 = 1'b1;
        tick();
        tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_cnt", done_cnt, 0);
        chk("rst_y", y, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_flags", {zero, parity}, 0);
        rst_n = 1'b1; rst2 = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_rst_vld", out_valid, 0);

        // T2: all eight ops
        for (int k = 0; k < 8; k++) begin
            run1(3'(k), TA, TB, exp8[k], exp8[k] == 0, ^exp8[k]);
        end

        // T3: flags
        run1(3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        run1(3'b111, 32'h0000_0007, 32'h0, 32'h7, 1'b0, 1'b1);
        tick();
        chk("cnt_10", done_cnt, 10);
        chk("idle_vld", out_valid, 0);

        // T4: back-to-back stream with a 3-cycle stall
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_cnt0", done_cnt, 0);
        sent = 0; got = 0; hold_v = 1'b0; held = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (sent < 6);
            op        = 3'(sent);
            a         = TA;
            b         = TB;
            #1;
            if (out_valid) begin
                if (hold_v) chk("t4_hold", y, held);
                if (out_ready) begin
                    chk($sformatf("t4_y%0d", got), y, exp8[got]);
                    got++;
                    hold_v = 1'b0;
                end else begin
                    chk("t4_inrdy", in_ready, 0);
                    held   = y;
                    hold_v = 1'b1;
                end
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_got", got, 6);
        chk("t4_cnt", done_cnt, 6);

        // T5: 17 handshakes on the 4-bit counter
        sent = 0; got = 0;
        for (int c = 0; c < 80 && got < 17; c++) begin
            iv2 = (sent < 17);
            op2 = 3'b111;
            a2  = 32'(sent + 1);
            b2  = 32'h0;
            or2 = 1'b1;
            #1;
            if (ov2) begin
                chk($sformatf("t5_y%0d", got), y2, 32'(got + 1));
                got++;
            end
            if (iv2 && ir2) sent++;
            tick();
        end
        iv2 = 1'b0;
        chk("t5_got", got, 17);
        chk("t5_wrap", dc2, 1);

        // T6: reset while two ops are in flight (STAGES=3)
        iv2 = 1'b1; op2 = 3'b111; a2 = 32'hAA;
        tick();
        a2 = 32'hBB;
        tick();
        iv2 = 1'b0; rst2 = 1'b0;
        tick();
        rst2 = 1'b1;
        chk("t6_cnt0", dc2, 0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t6_novld%0d", c), ov2, 0);
            tick();
        end
        iv2 = 1'b1; a2 = 32'h5;
        tick();
        iv2 = 1'b0;
        chk("t6_lat1", ov2, 0);
        tick();
        chk("t6_lat2", ov2, 0);
        tick();
        chk("t6_lat3", ov2, 1);
        chk("t6_y", y2, 32'h5);
        tick();
        chk("t6_cnt1", dc2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
